// File: rtl/rst_ctrl_pkg.sv
// Shared constants and types for the reset controller: register map, software
// reset key, cause bit positions and FSM state encoding.
package rst_ctrl_pkg;

  localparam logic [7:0] ADDR_HOLD  = 8'h44;
  localparam logic [7:0] ADDR_CAUSE = 8'h55;
  localparam logic [7:0] ADDR_COUNT = 8'h66;
  localparam logic [7:0] ADDR_SWRST = 8'h77;

  localparam logic [20:0] SWRST_KEY = 21'h1;

  localparam int CAUSE_WDT = 0;
  localparam int CAUSE_SW  = 1;

  typedef enum logic [1:0] {
    HOLD_RST,
    GUARD,
    RUN
  } rst_state_t;

endpackage

// File: rtl/rst_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; cleared by the
// asynchronous active-low reset.
module sat_counter #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rst_ctrl.sv
// Reset controller: stretches power-on, watchdog and software resets into a
// sequenced CPU/WDT reset, with a small register slave for hold, cause and count.
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int                DATA_W       = 21,
  parameter int                ADDR_W       = 8,
  parameter logic [DATA_W-1:0] DEFAULT_HOLD = 21'h8,
  parameter int                GUARD_CYCLES = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              wren,
  input  logic              rden,
  output logic [DATA_W-1:0] prdata,
  input  logic              wdt_reset_trig,
  output logic              cpu_rst,
  output logic              wdt_rst,
  output logic [1:0]        rst_cause
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0]     GONE = {{(GW-1){1'b0}}, 1'b1};

  rst_state_t        r_state, w_nextState;
  logic [DATA_W-1:0] r_holdCnt, w_nextHoldCnt;
  logic [GW-1:0]     r_guardCnt, w_nextGuardCnt;
  logic              r_cpuRst;
  logic [DATA_W-1:0] r_hold;
  logic [1:0]        r_cause;
  logic [DATA_W-1:0] r_prdata;
  logic [DATA_W-1:0] w_count;
  logic [DATA_W-1:0] w_rdData;
  logic [DATA_W-1:0] w_holdLoad;
  logic              w_run, w_wdtEvt, w_swEvt, w_wrHold, w_wrCause;
  logic [1:0]        w_clrMask, w_setMask;

  // Triggers only count as events while running; HOLD_RST and GUARD swallow them.
  assign w_run      = (r_state == RUN);
  assign w_wdtEvt   = w_run && wdt_reset_trig;
  assign w_swEvt    = w_run && wren && (paddr == ADDR_SWRST) && (pwdata == SWRST_KEY);
  assign w_wrHold   = wren && (paddr == ADDR_HOLD);
  assign w_wrCause  = wren && (paddr == ADDR_CAUSE);
  assign w_holdLoad = (r_hold == '0) ? ONE : r_hold;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= HOLD_RST;
      r_holdCnt  <= DEFAULT_HOLD;
      r_guardCnt <= '0;
      r_cpuRst   <= 1'b1;
    end else begin
      r_state    <= w_nextState;
      r_holdCnt  <= w_nextHoldCnt;
      r_guardCnt <= w_nextGuardCnt;
      r_cpuRst   <= (w_nextState == HOLD_RST);
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextHoldCnt  = r_holdCnt;
    w_nextGuardCnt = r_guardCnt;
    case (r_state)
      HOLD_RST: begin
        if (r_holdCnt <= ONE) begin
          w_nextState    = GUARD;
          w_nextGuardCnt = GW'(GUARD_CYCLES);
        end else begin
          w_nextHoldCnt = r_holdCnt - ONE;
        end
      end
      GUARD: begin
        if (r_guardCnt <= GONE) begin
          w_nextState = RUN;
        end else begin
          w_nextGuardCnt = r_guardCnt - GONE;
        end
      end
      RUN: begin
        if (w_wdtEvt || w_swEvt) begin
          w_nextState   = HOLD_RST;
          w_nextHoldCnt = w_holdLoad;
        end
      end
      default: w_nextState = HOLD_RST;
    endcase
  end

  always_comb begin
    w_rdData = '0;
    case (paddr)
      ADDR_HOLD:  w_rdData = r_hold;
      ADDR_CAUSE: w_rdData = {{(DATA_W-2){1'b0}}, r_cause};
      ADDR_COUNT: w_rdData = w_count;
      default:    w_rdData = '0;
    endcase
  end

  // A new event in the same cycle as a write-1-to-clear keeps its cause bit set.
  always_comb begin
    w_clrMask = w_wrCause ? pwdata[1:0] : 2'b00;
    w_setMask = 2'b00;
    w_setMask[CAUSE_WDT] = w_wdtEvt;
    w_setMask[CAUSE_SW]  = w_swEvt;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_hold   <= DEFAULT_HOLD;
      r_cause  <= 2'b00;
      r_prdata <= '0;
    end else begin
      if (w_wrHold) r_hold <= pwdata;
      r_cause <= (r_cause & ~w_clrMask) | w_setMask;
      if (rden && !wren) r_prdata <= w_rdData;
    end
  end

  sat_counter #(.W(DATA_W)) u_count (
    .clk     (pclk),
    .rst_n   (presetn),
    .i_en    (w_wdtEvt),
    .o_count (w_count)
  );

  assign prdata    = r_prdata;
  assign cpu_rst   = r_cpuRst;
  assign wdt_rst   = r_cpuRst;
  assign rst_cause = r_cause;

endmodule
